distributor_1_8_32: RTL and testbench
=====================================

// Module: distributor_1_8_32
// PURPOSE
//  Registered 1-to-8 distributor (demultiplexer) for 32-bit words; inverse of the 8:1 word selector.
//  Accepts one word per cycle on a valid/ready input stream. Routes it to the output channel named by s,
//  or to all channels when bcast=1. Each channel has a 1-entry output register with its own
//  valid/ready handshake and a delivered-word counter.
// PARAMETERS
//  N_CH    8   number of output channels; power of 2; SEL_W = $clog2(N_CH)
//  DATA_W  32  word width
//  CNT_W   8   width of per-channel delivered-word counters
// PORTS
//  clk       in   1                 clock, rising edge
//  rst_n     in   1                 reset, synchronous, active-low
//  in_valid  in   1                 input word present
//  in_ready  out  1                 distributor can take the word this cycle
//  s         in   SEL_W             destination channel (ignored when bcast=1)
//  bcast     in   1                 1 = write word to all N_CH channels
//  x         in   DATA_W            input word
//  y         out  DATA_W x [N_CH]   per-channel output word (unpacked array y[N_CH-1:0])
//  y_valid   out  N_CH              per-channel output word valid
//  y_ready   in   N_CH              per-channel consumer ready
//  cnt       out  CNT_W x [N_CH]    per-channel delivered-word count (unpacked array)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): y_valid<=0, every y<=0, every cnt<=0.
//   in_ready is forced 0 while rst_n=0.
//   Any pending or held words are discarded, including on reset mid-operation.
//  ch_free[i] = !y_valid[i] | y_ready[i].
//  in_ready = bcast ? &ch_free : ch_free[s].
//   Combinational; depends only on s, bcast, y_valid and y_ready. It never depends on in_valid.
//  accept = in_valid & in_ready.
//   On accept, each target channel loads y[i]<=x and y_valid[i]<=1.
//   Target = channel s, or all channels if bcast.
//  Latency: the word is visible on y[i]/y_valid[i] the cycle after accept.
//  Output transfer on channel i: y_valid[i] & y_ready[i] at a clk edge.
//   If channel i is not loaded in that cycle, y_valid[i]<=0 and y[i] holds its last value (not cleared).
//  Simultaneous drain and load on the same channel: y_valid stays 1 and y takes the new word.
//   This gives full throughput of 1 word/cycle per channel.
//  While y_valid[i]=1 and y_ready[i]=0, y[i] and y_valid[i] are held stable.
//  Non-target channels are unaffected by an accept.
//  Producer rule: once in_valid=1, s, bcast and x stay stable until accept.
//   The block does not depend on this rule for correctness.
//  Broadcast is all-or-nothing.
//   The word is accepted only when every channel is free; no partial broadcast ever occurs.
//  cnt[i] increments by 1 on each output transfer of channel i.
//   It wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
//  s is always in range for power-of-2 N_CH. No other states exist.
//   Each channel is a 2-state register: EMPTY (y_valid=0) and FULL (y_valid=1).
//   EMPTY->FULL on load; FULL->EMPTY on drain without load; FULL->FULL on drain+load or stall.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with in_valid=1
//    -> in_ready=0, y_valid=8'h00, all y=0, all cnt=0.
//  2 Sweep: s=0..7 with x=32'h1<<(4*s), bcast=0, y_ready=8'hFF
//    -> y[s]=x one cycle later, y_valid=1<<s for one cycle, cnt[s]=1 for each s.
//  3 Backpressure: y_ready[3]=0; send s=3 32'hDEADBEEF, then s=3 32'h12345678
//    -> second word stalls (in_ready=0) and y[3] holds DEADBEEF.
//    Raise y_ready[3] -> 12345678 is accepted that cycle; cnt[3] goes 1, then 2.
//  4 Broadcast: y_valid[5]=1, y_ready[5]=0, bcast=1, x=32'hA5A5A5A5
//    -> in_ready=0 and no channel changes.
//    Release y_ready[5] -> next cycle y_valid=8'hFF and all y=A5A5A5A5.
//  5 Throughput: 10 back-to-back words on s=6 with y_ready=8'hFF
//    -> in_ready stays 1, 10 consecutive transfers, cnt[6]=10.
//  6 Wrap/reset: 256 deliveries on ch 0 -> cnt[0]=0.
//    With y_valid=8'hFF, drive rst_n=0 for one edge -> y_valid=8'h00 next cycle.

Source files
------------

// File: rtl/distributor_1_8_32.sv
// Registered 1-to-N_CH word distributor with per-channel 1-entry output registers and transfer counters.
// Latency 1 cycle. A word waits at the input until its target channel (or all channels when bcast=1) can take it.
module distributor_1_8_32 #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  s,
  input  logic              bcast,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y [N_CH-1:0],
  output logic [N_CH-1:0]   y_valid,
  input  logic [N_CH-1:0]   y_ready,
  output logic [CNT_W-1:0]  cnt [N_CH-1:0]
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [N_CH-1:0] ch_free;
  logic [N_CH-1:0] load;
  logic [N_CH-1:0] xfer;
  logic            accept;

  // A channel can load when empty or when its current word leaves this cycle.
  assign ch_free  = ~y_valid | y_ready;
  assign in_ready = rst_n & (bcast ? (&ch_free) : ch_free[s]);
  assign accept   = in_valid & in_ready;
  assign xfer     = y_valid & y_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      if (bcast) begin
        load = '1;
      end else begin
        load[s] = 1'b1;
      end
    end
  end

  // Each channel is EMPTY/FULL, encoded directly by y_valid[i].
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_valid <= '0;
      for (int i = 0; i < N_CH; i++) begin
        y[i]   <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (load[i]) begin
          y[i]       <= x;
          y_valid[i] <= 1'b1;
        end else if (xfer[i]) begin
          y_valid[i] <= 1'b0;
        end
        if (xfer[i]) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_distributor_1_8_32.sv
// Directed test of distributor_1_8_32: reset, routing sweep, backpressure, broadcast, throughput, counter wrap.
module tb_distributor_1_8_32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  s;
  logic        bcast;
  logic [31:0] x;
  logic [31:0] y [7:0];
  logic [7:0]  y_valid;
  logic [7:0]  y_ready;
  logic [7:0]  cnt [7:0];

  int total = 0;
  int bad   = 0;

  distributor_1_8_32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s        (s),
    .bcast    (bcast),
    .x        (x),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .cnt      (cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    bcast    = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    s        = 3'd0;
    bcast    = 1'b0;
    x        = 32'hFFFF_FFFF;
    y_ready  = 8'h00;

    // Reset held for two edges with a word offered.
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("rst_y", y[i], 32'd0);
      chk("rst_cnt", 32'(cnt[i]), 32'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();

    // Routing sweep over every channel.
    y_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      s        = 3'(i);
      x        = 32'h1 << (4 * i);
      in_valid = 1'b1;
      #1;
      chk("sweep_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("sweep_y", y[i], 32'h1 << (4 * i));
      chk("sweep_y_valid", 32'(y_valid), 32'(8'h1 << i));
      tick();
      chk("sweep_cnt", 32'(cnt[i]), 32'd1);
      chk("sweep_drained", 32'(y_valid), 32'd0);
    end

    // Backpressure on channel 3.
    do_reset();
    y_ready  = 8'hF7;
    s        = 3'd3;
    x        = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    #1;
    chk("bp_first_ready", 32'(in_ready), 32'd1);
    tick();
    x = 32'h1234_5678;
    #1;
    chk("bp_stall_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_y", y[3], 32'hDEAD_BEEF);
    chk("bp_hold_valid", 32'(y_valid), 32'h08);
    chk("bp_cnt0", 32'(cnt[3]), 32'd0);
    tick();
    chk("bp_hold_y2", y[3], 32'hDEAD_BEEF);
    chk("bp_stall_ready2", 32'(in_ready), 32'd0);
    y_ready = 8'hFF;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp_second_y", y[3], 32'h1234_5678);
    chk("bp_second_valid", 32'(y_valid), 32'h08);
    chk("bp_cnt1", 32'(cnt[3]), 32'd1);
    tick();
    chk("bp_cnt2", 32'(cnt[3]), 32'd2);
    chk("bp_empty", 32'(y_valid), 32'd0);

    // Broadcast blocked by one stalled channel, then released.
    y_ready  = 8'hDF;
    s        = 3'd5;
    x        = 32'h5555_5555;
    in_valid = 1'b1;
    tick();
    bcast = 1'b1;
    x     = 32'hA5A5_A5A5;
    #1;
    chk("bc_blocked_ready", 32'(in_ready), 32'd0);
    tick();
    chk("bc_no_change_valid", 32'(y_valid), 32'h20);
    chk("bc_no_change_y5", y[5], 32'h5555_5555);
    chk("bc_no_change_y0", y[0], 32'd0);
    chk("bc_no_change_y3", y[3], 32'h1234_5678);
    y_ready = 8'hFF;
    #1;
    chk("bc_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    bcast    = 1'b0;
    #1;
    chk("bc_all_valid", 32'(y_valid), 32'hFF);
    for (int i = 0; i < 8; i++) begin
      chk("bc_all_y", y[i], 32'hA5A5_A5A5);
    end
    tick();
    chk("bc_drained", 32'(y_valid), 32'd0);
    chk("bc_cnt5", 32'(cnt[5]), 32'd2);
    chk("bc_cnt0", 32'(cnt[0]), 32'd1);
    chk("bc_cnt3", 32'(cnt[3]), 32'd3);

    // Back-to-back words on channel 6.
    do_reset();
    y_ready  = 8'hFF;
    s        = 3'd6;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      x = 32'hC000_0000 + 32'(k);
      #1;
      chk("tp_in_ready", 32'(in_ready), 32'd1);
      if (k > 0) begin
        chk("tp_y", y[6], 32'hC000_0000 + 32'(k - 1));
        chk("tp_valid", 32'(y_valid), 32'h40);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("tp_last_y", y[6], 32'hC000_0009);
    chk("tp_last_valid", 32'(y_valid), 32'h40);
    tick();
    chk("tp_cnt", 32'(cnt[6]), 32'd10);
    chk("tp_empty", 32'(y_valid), 32'd0);

    // Counter wrap after 256 deliveries on channel 0.
    do_reset();
    y_ready  = 8'hFF;
    s        = 3'd0;
    x        = 32'h0000_0042;
    in_valid = 1'b1;
    repeat (256) tick();
    chk("wrap_cnt255", 32'(cnt[0]), 32'd255);
    in_valid = 1'b0;
    tick();
    chk("wrap_cnt0", 32'(cnt[0]), 32'd0);
    chk("wrap_other_cnt", 32'(cnt[1]), 32'd0);

    // Reset while every channel holds a word.
    y_ready  = 8'h00;
    bcast    = 1'b1;
    x        = 32'h0000_0077;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    bcast    = 1'b0;
    #1;
    chk("mid_full", 32'(y_valid), 32'hFF);
    chk("mid_y2", y[2], 32'h0000_0077);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(y_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_y2", y[2], 32'd0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
